// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: segmented pipelined ripple-carry adder computing S = A + B + CI
// Ports: C clock, R async active-low reset, E pipeline advance enable,
//        I_VLD/A/B/CI operand slot in, O_VLD/S/CO registered result NSEG enabled edges later.
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             I_VLD,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             O_VLD,
  output logic [WIDTH-1:0] S,
  output logic             CO
);
  localparam int NSEG = WIDTH / SEG_W;
  genvar k, j;
  for (k = 0; k < NSEG; k++) begin : g_st
    localparam int BW = WIDTH - k * SEG_W;
    // x carries finished sum bits below segment k and untouched A bits from segment k up
    logic [WIDTH-1:0] x_in, x_nx, x_q;
    // b keeps only the B segments not yet added, segment k at the bottom
    logic [BW-1:0]    b_in;
    logic [SEG_W-1:0] s_seg;
    logic [SEG_W:0]   cy;
    logic             v_in, c_q, v_q;
    if (k == 0) begin : g_head
      assign x_in  = A;
      assign b_in  = B;
      assign cy[0] = CI;
      assign v_in  = I_VLD;
    end else begin : g_tail
      assign x_in  = g_st[k-1].x_q;
      assign b_in  = g_st[k-1].g_fwd.b_q;
      assign cy[0] = g_st[k-1].c_q;
      assign v_in  = g_st[k-1].v_q;
    end
    for (j = 0; j < SEG_W; j++) begin : g_bit
      logic p, g;
      assign p          = x_in[k*SEG_W+j] ^ b_in[j];
      assign g          = x_in[k*SEG_W+j] & b_in[j];
      assign s_seg[j]   = p ^ cy[j];
      assign cy[j+1]    = p ? cy[j] : g;
    end
    always_comb begin
      x_nx = x_in;
      x_nx[k*SEG_W +: SEG_W] = s_seg;
    end
    always_ff @(posedge C or negedge R)
      if (!R) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (E) begin
        x_q <= x_nx;
        c_q <= cy[SEG_W];
        v_q <= v_in;
      end
    if (k < NSEG - 1) begin : g_fwd
      logic [BW-SEG_W-1:0] b_q;
      always_ff @(posedge C or negedge R)
        if (!R) b_q <= '0;
        else if (E) b_q <= b_in[BW-1:SEG_W];
    end
  end
  assign S     = g_st[NSEG-1].x_q;
  assign CO    = g_st[NSEG-1].c_q;
  assign O_VLD = g_st[NSEG-1].v_q;
endmodule
